// File: rtl/mem_stage_if.sv
// EX -> MEM -> WB pipeline bundle plus the data-SRAM response side of the memory stage.
// The stage itself connects through the slave modport; the upstream/downstream driver uses master.
interface mem_stage_if;
   logic        ex_valid;
   logic        ex_ready_go;
   logic        mem_allow_in;
   logic [31:0] ex_pc;
   logic [31:0] ex_result;
   logic        ex_rf_we;
   logic [4:0]  ex_rf_waddr;
   logic [2:0]  ex_mem_op;
   logic        ex_is_load;
   logic        ex_req_sent;
   logic        ex_except;
   logic        ex_inflight_kill;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        wb_allow_in;
   logic        wb_flush;
   logic        mem_to_wb_valid;
   logic [31:0] mem_pc;
   logic [31:0] mem_final_result;
   logic        mem_rf_we;
   logic [4:0]  mem_rf_waddr;
   logic        mem_except;
   logic        mem_bypass_block;

   modport slave (
      input  ex_valid, ex_ready_go, ex_pc, ex_result, ex_rf_we, ex_rf_waddr,
             ex_mem_op, ex_is_load, ex_req_sent, ex_except, ex_inflight_kill,
             data_sram_data_ok, data_sram_rdata, wb_allow_in, wb_flush,
      output mem_allow_in, mem_to_wb_valid, mem_pc, mem_final_result,
             mem_rf_we, mem_rf_waddr, mem_except, mem_bypass_block
   );

   modport master (
      output ex_valid, ex_ready_go, ex_pc, ex_result, ex_rf_we, ex_rf_waddr,
             ex_mem_op, ex_is_load, ex_req_sent, ex_except, ex_inflight_kill,
             data_sram_data_ok, data_sram_rdata, wb_allow_in, wb_flush,
      input  mem_allow_in, mem_to_wb_valid, mem_pc, mem_final_result,
             mem_rf_we, mem_rf_waddr, mem_except, mem_bypass_block
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its in-order data-SRAM
// response, extracts/extends load data and drops responses orphaned by a WB flush.
module mem_stage #(
   parameter int DISCARD_W = 2
) (
   input logic        clk,
   input logic        reset,
   mem_stage_if.slave bus
);
   localparam logic [DISCARD_W:0] DISCARD_MAX = {1'b0, {DISCARD_W{1'b1}}};

   logic                 valid_q;
   logic                 buf_valid_q;
   logic [31:0]          buf_data_q;
   logic [31:0]          pc_q;
   logic [31:0]          result_q;
   logic                 rf_we_q;
   logic [4:0]           rf_waddr_q;
   logic [2:0]           mem_op_q;
   logic                 is_load_q;
   logic                 req_sent_q;
   logic                 except_q;
   logic [DISCARD_W-1:0] discard_cnt_q;
   logic [DISCARD_W-1:0] discard_cnt_d;

   logic                 waiting;
   logic                 cur_ok;
   logic                 ready_go;
   logic                 allow_in;
   logic                 load_en;
   logic [DISCARD_W:0]   discard_sum;

   assign waiting  = valid_q & req_sent_q & ~except_q & ~buf_valid_q;
   assign cur_ok   = bus.data_sram_data_ok & (discard_cnt_q == '0);
   assign ready_go = ~waiting | cur_ok;
   assign allow_in = ~valid_q | (ready_go & bus.wb_allow_in);
   assign load_en  = allow_in & bus.ex_valid & bus.ex_ready_go & ~bus.wb_flush;

   // Flushed-away requests (ours if still outstanding, plus EX's killed one) and a
   // same-cycle stale response are folded into a single signed-free net update.
   always_comb begin
      discard_sum = {1'b0, discard_cnt_q}
                  + {{DISCARD_W{1'b0}}, bus.wb_flush & waiting & ~cur_ok}
                  + {{DISCARD_W{1'b0}}, bus.wb_flush & bus.ex_inflight_kill}
                  - {{DISCARD_W{1'b0}}, bus.data_sram_data_ok & (discard_cnt_q != '0)};
      discard_cnt_d = discard_sum[DISCARD_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (discard_sum <= DISCARD_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q       <= 1'b0;
         buf_valid_q   <= 1'b0;
         buf_data_q    <= '0;
         pc_q          <= '0;
         result_q      <= '0;
         rf_we_q       <= 1'b0;
         rf_waddr_q    <= '0;
         mem_op_q      <= '0;
         is_load_q     <= 1'b0;
         req_sent_q    <= 1'b0;
         except_q      <= 1'b0;
         discard_cnt_q <= '0;
      end else begin
         discard_cnt_q <= discard_cnt_d;
         if (bus.wb_flush) begin
            valid_q     <= 1'b0;
            buf_valid_q <= 1'b0;
         end else if (allow_in) begin
            valid_q     <= bus.ex_valid & bus.ex_ready_go;
            buf_valid_q <= 1'b0;
         end else if (cur_ok & waiting & ~bus.wb_allow_in) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= bus.data_sram_rdata;
         end
         if (load_en) begin
            pc_q       <= bus.ex_pc;
            result_q   <= bus.ex_result;
            rf_we_q    <= bus.ex_rf_we;
            rf_waddr_q <= bus.ex_rf_waddr;
            mem_op_q   <= bus.ex_mem_op;
            is_load_q  <= bus.ex_is_load;
            req_sent_q <= bus.ex_req_sent;
            except_q   <= bus.ex_except;
         end
      end
   end

   logic [31:0] raw;
   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   assign raw = buf_valid_q ? buf_data_q : bus.data_sram_rdata;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = raw[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = lane[result_q[1:0]];
   assign half_sel = result_q[1] ? raw[31:16] : raw[15:0];

   always_comb begin
      load_data = raw;
      case (mem_op_q)
         3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
         3'd2:    load_data = {{16{half_sel[15]}}, half_sel};
         3'd3:    load_data = {24'd0, byte_sel};
         3'd4:    load_data = {16'd0, half_sel};
         default: load_data = raw;
      endcase
   end

   assign bus.mem_allow_in     = allow_in;
   assign bus.mem_to_wb_valid  = valid_q & ready_go;
   assign bus.mem_pc           = pc_q;
   assign bus.mem_final_result = is_load_q ? load_data : result_q;
   assign bus.mem_rf_we        = rf_we_q & ~except_q;
   assign bus.mem_rf_waddr     = rf_waddr_q;
   assign bus.mem_except       = except_q;
   assign bus.mem_bypass_block = valid_q & is_load_q & rf_we_q & waiting & ~cur_ok;
endmodule
